alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL provide reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-003 SHALL provide req0_valid / req1_valid  input  1 each  requester n presents an operation.
REQ-004 SHALL provide req0_ready / req1_ready  output  1 each  operation from requester n accepted this cycle.
REQ-005 SHALL provide req0_ctrl / req1_ctrl  input  4 each  ALU control code (bit3 shift-16, bit2 invert-B/carry-in, bits1:0 AND/OR/ADD/EQ).
REQ-006 SHALL provide req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-007 SHALL provide alu_ctrl  output  4, alu_a  output  32, alu_b  output  32  drive the shared ALU.
REQ-008 SHALL provide alu_ans  input  32  combinational ALU result.
REQ-009 SHALL provide rsp_valid  output  1, rsp_id  output  1, rsp_data  output  32  response channel.
REQ-010 SHALL provide rsp_ready  input  1  consumer accepts response.
REQ-011 SHALL provide busy  output  1, op_cnt  output  16  busy = state not IDLE; op_cnt = completed responses.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: if any reqN_valid, SHALL grant one requester, assert its reqN_ready combinationally that cycle, latch ctrl/a/b/id, move to EXEC.
REQ-014 IDLE with no valid request SHALL stay IDLE, both ready low.
REQ-015 Arbitration SHALL be round-robin: priority pointer selects preferred requester; only one ready high per cycle.
REQ-016 After a grant, pointer SHALL point to the non-granted requester; pointer unchanged when no grant.
REQ-017 Single valid requester SHALL be granted regardless of pointer.
REQ-018 reqN_ready SHALL be low in EXEC and RESP; requests arriving then are held off, never dropped or queued internally.
REQ-019 alu_ctrl/alu_a/alu_b SHALL be driven from latched registers in all states (held stable from grant until next grant).
REQ-020 EXEC: SHALL capture alu_ans into rsp_data and latched id into rsp_id at the clock edge, move to RESP (EXEC lasts exactly 1 cycle).
REQ-021 RESP: rsp_valid SHALL be high; rsp_data/rsp_id SHALL stay stable until rsp_ready sampled high.
REQ-022 RESP with rsp_ready=1 SHALL return to IDLE and increment op_cnt by 1, modulo 2^16 (0xFFFF -> 0x0000).
REQ-023 RESP with rsp_ready=0 SHALL remain in RESP indefinitely.
REQ-024 Latency: grant edge -> rsp_valid high after exactly 2 rising edges; minimum 3 cycles per operation.
REQ-025 No new grant SHALL occur in the cycle the response handshake completes (grant only in IDLE).
REQ-026 Block SHALL not interpret ctrl; all 16 codes pass through unchanged.

Reset
REQ-027 reset=0 at a rising edge SHALL force state IDLE, pointer to requester 0, op_cnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, latched ctrl/a/b=0, both ready low, busy=0.
REQ-028 Reset SHALL override any state, including mid-EXEC or RESP; in-flight operation is discarded and op_cnt not incremented.
REQ-029 reqN_ready SHALL be low while reset is asserted.

Verification
REQ-030 After reset, req0 ctrl=4'b0010 a=5 b=3, rsp_ready=1 -> req0_ready high cycle 0, rsp_valid cycle 2, rsp_id=0, rsp_data=8, op_cnt=1.
REQ-031 Both valid continuously, req0 ctrl=4'b0110 a=10 b=4, req1 ctrl=4'b1001 a=0 b=0x1234 -> grants alternate 0,1,0; responses 6 (id0), 0x12340000 (id1), 6 (id0).
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data held, req ready low throughout, op_cnt unchanged until handshake.
REQ-033 Reset driven low during EXEC -> next cycle IDLE, rsp_valid=0, op_cnt=0, pointer=0; following req1-only request granted normally.
REQ-034 op_cnt preloaded to 0xFFFF via 65535 operations (or forced) -> next handshake yields op_cnt=0x0000.
REQ-035 req1 only, ctrl=4'b0011 a=b=0x7 -> rsp_data=1, rsp_id=1; then both valid -> req0 granted (pointer moved to 0).

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each granted operation runs IDLE -> EXEC -> RESP and completes on the rsp handshake.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_ctrl,
    input  logic [3:0]  req1_ctrl,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_ans,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    output logic        busy,
    output logic [15:0] op_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        id_q, id_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [15:0] op_cnt_q, op_cnt_d;
    logic        grant0, grant1;

    // ptr_q = 1 means requester 1 wins a tie; grants are suppressed while in reset
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == ST_IDLE && reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~ptr_q;
                grant1 = ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ctrl_d     = ctrl_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        op_cnt_d   = op_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant0 || grant1) begin
                    state_d = ST_EXEC;
                    ptr_d   = grant0;
                    id_d    = grant1;
                    ctrl_d  = grant1 ? req1_ctrl : req0_ctrl;
                    a_d     = grant1 ? req1_a : req0_a;
                    b_d     = grant1 ? req1_b : req0_b;
                end
            end
            ST_EXEC: begin
                state_d    = ST_RESP;
                rsp_data_d = alu_ans;
                rsp_id_d   = id_q;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d  = ST_IDLE;
                    op_cnt_d = op_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            ctrl_q     <= 4'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            id_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 32'd0;
            op_cnt_q   <= 16'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ctrl_q     <= ctrl_d;
            a_q        <= a_d;
            b_q        <= b_d;
            id_q       <= id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            op_cnt_q   <= op_cnt_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_ctrl   = ctrl_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign op_cnt     = op_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (in-flight op, age since grant, tie pointer, counter).
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, alu_ans;
    logic        rsp_valid, rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_ready;
    logic        busy;
    logic [15:0] op_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    logic        m_inflight = 1'b0;
    int          m_age = 0;
    logic        m_ptr = 1'b0;
    logic [15:0] m_cnt = 16'd0;
    logic        m_pid = 1'b0;
    logic [31:0] m_pdata = 32'd0;
    logic        m_rid = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    logic [3:0]  m_ctrl = 4'd0;
    logic [31:0] m_a = 32'd0;
    logic [31:0] m_b = 32'd0;
    logic        hs0 = 1'b0;
    logic        hs1 = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] bb, r;
        bb = c[2] ? ~b : b;
        case (c[1:0])
            2'd0:    r = a & bb;
            2'd1:    r = a | bb;
            2'd2:    r = a + bb + {31'd0, c[2]};
            default: r = {31'd0, a == bb};
        endcase
        if (c[3]) r = r << 16;
        return r;
    endfunction

    assign alu_ans = alu_f(alu_ctrl, alu_a, alu_b);

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy), .op_cnt(op_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output with the model, then advance the model across the coming edge.
    task automatic at_neg();
        logic g0, g1;
        @(negedge clk);
        g0 = 1'b0;
        g1 = 1'b0;
        if (!m_inflight && reset) begin
            if (req0_valid && req1_valid) begin
                g0 = !m_ptr;
                g1 = m_ptr;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        chk("req0_ready", 32'(req0_ready), 32'(g0));
        chk("req1_ready", 32'(req1_ready), 32'(g1));
        chk("busy", 32'(busy), 32'(m_inflight));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_inflight && m_age == 2));
        chk("rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("rsp_data", rsp_data, m_rdata);
        chk("op_cnt", 32'(op_cnt), 32'(m_cnt));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
        hs0 = req0_ready;
        hs1 = req1_ready;
        if (!reset) begin
            m_inflight = 1'b0; m_age = 0; m_ptr = 1'b0; m_cnt = 16'd0;
            m_pid = 1'b0; m_pdata = 32'd0; m_rid = 1'b0; m_rdata = 32'd0;
            m_ctrl = 4'd0; m_a = 32'd0; m_b = 32'd0;
        end else if (m_inflight) begin
            if (m_age == 1) begin
                m_age   = 2;
                m_rid   = m_pid;
                m_rdata = m_pdata;
            end else if (rsp_ready) begin
                m_inflight = 1'b0;
                m_cnt      = m_cnt + 16'd1;
                $display("RSP id=%0d data=%08h op_cnt=%0d", m_rid, m_rdata, m_cnt);
            end
        end else if (g0 || g1) begin
            m_inflight = 1'b1;
            m_age      = 1;
            m_pid      = g1;
            m_ctrl     = g1 ? req1_ctrl : req0_ctrl;
            m_a        = g1 ? req1_a : req0_a;
            m_b        = g1 ? req1_b : req0_b;
            m_pdata    = alu_f(m_ctrl, m_a, m_b);
            m_ptr      = !g1;
        end
    endtask

    task automatic at_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        at_neg();
        at_pos();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(n >= 20), 32'd0);
    endtask

    initial begin
        reset = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_ctrl = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_ctrl = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
        repeat (3) cyc();
        reset = 1'b1;

        // single add from requester 0
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd5; req0_b = 32'd3; rsp_ready = 1'b1;
        at_neg(); chk("add_ready0", 32'(req0_ready), 32'd1); at_pos();
        req0_valid = 1'b0;
        at_neg(); chk("add_exec_rv", 32'(rsp_valid), 32'd0); at_pos();
        at_neg();
        chk("add_rv", 32'(rsp_valid), 32'd1);
        chk("add_data", rsp_data, 32'd8);
        chk("add_id", 32'(rsp_id), 32'd0);
        at_pos();
        at_neg(); chk("add_cnt", 32'(op_cnt), 32'd1); at_pos();

        // reset, then both requesters valid continuously
        reset = 1'b0; cyc(); reset = 1'b1;
        req0_valid = 1'b1; req0_ctrl = 4'b0110; req0_a = 32'd10; req0_b = 32'd4;
        req1_valid = 1'b1; req1_ctrl = 4'b1001; req1_a = 32'd0; req1_b = 32'h1234;
        for (int c = 0; c < 9; c++) begin
            at_neg();
            case (c)
                0, 6: begin
                    chk("rr_g0_ready0", 32'(req0_ready), 32'd1);
                    chk("rr_g0_ready1", 32'(req1_ready), 32'd0);
                end
                3: begin
                    chk("rr_g1_ready0", 32'(req0_ready), 32'd0);
                    chk("rr_g1_ready1", 32'(req1_ready), 32'd1);
                end
                2, 8: begin
                    chk("rr_sub_data", rsp_data, 32'd6);
                    chk("rr_sub_id", 32'(rsp_id), 32'd0);
                end
                5: begin
                    chk("rr_shift_data", rsp_data, 32'h1234_0000);
                    chk("rr_shift_id", 32'(rsp_id), 32'd1);
                end
                default: ;
            endcase
            at_pos();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // requester 1 alone, equality compare; then a tie goes to requester 0
        req1_valid = 1'b1; req1_ctrl = 4'b0011; req1_a = 32'h7; req1_b = 32'h7;
        at_neg(); chk("eq_ready1", 32'(req1_ready), 32'd1); at_pos();
        req1_valid = 1'b0;
        cyc();
        at_neg();
        chk("eq_data", rsp_data, 32'd1);
        chk("eq_id", 32'(rsp_id), 32'd1);
        at_pos();
        req0_valid = 1'b1; req1_valid = 1'b1;
        at_neg(); chk("tie_ready0", 32'(req0_ready), 32'd1); at_pos();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("tie");

        // backpressure: response held five cycles while both requesters wait
        req0_valid = 1'b1; req0_ctrl = 4'b0010; req0_a = 32'd100; req0_b = 32'd23; rsp_ready = 1'b0;
        at_neg(); chk("bp_ready0", 32'(req0_ready), 32'd1); at_pos();
        req1_valid = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) begin
            at_neg();
            chk("bp_rv", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, 32'd123);
            chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
            chk("bp_cnt", 32'(op_cnt), 32'd5);
            at_pos();
        end
        rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        at_neg(); chk("bp_last_rv", 32'(rsp_valid), 32'd1); at_pos();
        at_neg(); chk("bp_cnt_after", 32'(op_cnt), 32'd6); at_pos();

        // reset lands while the operation is in EXEC
        req0_valid = 1'b1; req0_ctrl = 4'hF; req0_a = 32'hDEAD_BEEF; req0_b = 32'h0BAD_F00D;
        at_neg(); chk("rx_ready0", 32'(req0_ready), 32'd1); at_pos();
        req0_valid = 1'b0; reset = 1'b0;
        at_neg(); chk("rx_exec_busy", 32'(busy), 32'd1); at_pos();
        reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        at_neg();
        chk("rx_busy", 32'(busy), 32'd0);
        chk("rx_rv", 32'(rsp_valid), 32'd0);
        chk("rx_cnt", 32'(op_cnt), 32'd0);
        chk("rx_ptr_ready0", 32'(req0_ready), 32'd1);
        at_pos();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle("rx_tie");
        req1_valid = 1'b1;
        at_neg(); chk("rx_req1_ready", 32'(req1_ready), 32'd1); at_pos();
        req1_valid = 1'b0;
        wait_idle("rx_req1");

        // op_cnt wraps from 0xFFFF to 0
        force dut.op_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        at_neg();
        release dut.op_cnt_q;
        at_pos();
        req0_valid = 1'b1;
        cyc();
        req0_valid = 1'b0;
        wait_idle("wrap");
        at_neg(); chk("wrap_cnt", 32'(op_cnt), 32'd0); at_pos();

        // random traffic, occasional resets and backpressure
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 59) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (hs0 || !req0_valid) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_ctrl  = 4'($urandom);
                req0_a     = $urandom;
                req0_b     = $urandom_range(0, 1) ? req0_a : $urandom;
            end
            if (hs1 || !req1_valid) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_ctrl  = 4'($urandom);
                req1_a     = $urandom;
                req1_b     = $urandom_range(0, 1) ? req1_a : $urandom;
            end
            cyc();
        end
        reset = 1'b1; rsp_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
